// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the N-channel stereo audio mixer.
// The FSM gains a DCB state when AUDIO_MIXER_DCBLOCK_EN is defined.
package audio_mixer_pkg;

  // Default configuration, and the accumulator width that follows from it.
  localparam int NCH_DEFAULT = 4;
  localparam int IW_DEFAULT  = 10;
  localparam int GW_DEFAULT  = 6;
  localparam int ACCW        = IW_DEFAULT + GW_DEFAULT + $clog2(NCH_DEFAULT) + 1;

`ifdef AUDIO_MIXER_DCBLOCK_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2,
    DCB  = 2'd3
  } mix_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } mix_state_t;
`endif

  // Clamp a wide signed value into the signed range of an ow-bit word.
  function automatic logic signed [63:0] sat_to_ow(input logic signed [63:0] v,
                                                   input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/audio_dc_block.sv
// One-pole DC-blocking high-pass stage for one side of the mixer output.
// Only built when AUDIO_MIXER_DCBLOCK_EN is defined.
`ifdef AUDIO_MIXER_DCBLOCK_EN
module audio_dc_block
  import audio_mixer_pkg::*;
#(
  parameter int OW       = 15,
  parameter int DC_SHIFT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [OW-1:0] x,
  output logic [OW-1:0] y
);

  logic signed [OW-1:0] x_prev;
  logic signed [OW-1:0] y_next;
  logic signed [63:0]   wide;

  // Filter equation y = x - x_prev + y_prev - y_prev/2^DC_SHIFT, re-saturated.
  always_comb begin
    wide   = 64'($signed(x)) - 64'(x_prev) + 64'($signed(y))
           - (64'($signed(y)) >>> DC_SHIFT);
    y_next = OW'(sat_to_ow(wide, OW));
  end

  // Filter state advances once per mixed frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev <= '0;
      y      <= '0;
    end else if (en) begin
      x_prev <= $signed(x);
      y      <= y_next;
    end
  end

endmodule
`endif

// File: rtl/audio_mixer.sv
// Time-multiplexed N-channel stereo mixer with ramped per-channel L/R gains
// and saturated signed output for the sigma-delta DAC.
// Optional feature macro: AUDIO_MIXER_DCBLOCK_EN (adds a DC-blocking stage).
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IW       = 10,
  parameter int GW       = 6,
  parameter int OW       = 15,
  parameter int DC_SHIFT = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [NCH*IW-1:0]         in_samples,
  input  logic                      reg_wr,
  input  logic [$clog2(2*NCH)-1:0]  reg_addr,
  input  logic [GW-1:0]             reg_wdata,
  output logic [GW-1:0]             reg_rdata,
  output logic [OW-1:0]             out_l,
  output logic [OW-1:0]             out_r,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW    = $clog2(2*NCH);
  localparam int IDXW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC_W = IW + GW + $clog2(NCH) + 1;
  localparam int PW    = IW + GW + 1;
  localparam logic [GW-1:0]   UNITY    = {1'b1, {(GW-1){1'b0}}};
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  if (NCH < 1 || NCH > 16 || IW < 2 || GW < 2 || OW < IW || OW > 32 || DC_SHIFT < 1)
  begin : g_bad_cfg
    $error("audio_mixer: unsupported parameter set");
  end

  mix_state_t state, next_state;
  logic start_frame;
  logic ovr_hit;

  logic [NCH*IW-1:0]     snap;
  logic [GW-1:0]         tgt_l [NCH];
  logic [GW-1:0]         tgt_r [NCH];
  logic [GW-1:0]         cur_l [NCH];
  logic [GW-1:0]         cur_r [NCH];
  logic [IDXW-1:0]       idx;
  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;

  logic [IW-1:0]         raw;
  logic [GW-1:0]         g_l;
  logic [GW-1:0]         g_r;
  logic signed [IW-1:0]  s;
  logic signed [PW-1:0]  prod_l;
  logic signed [PW-1:0]  prod_r;
  logic signed [63:0]    wide_l;
  logic signed [63:0]    wide_r;
  logic signed [OW-1:0]  sat_l;
  logic signed [OW-1:0]  sat_r;

  // Move a current gain one step toward its target, never past it.
  function automatic logic [GW-1:0] ramp_step(input logic [GW-1:0] cur,
                                              input logic [GW-1:0] tgt);
    if (cur < tgt)      return cur + GW'(1);
    else if (cur > tgt) return cur - GW'(1);
    else                return cur;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; sample_en outside IDLE is an overrun and never restarts the frame.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    ovr_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en) begin
          start_frame = 1'b1;
          next_state  = ACC;
        end
      end
      ACC: begin
        ovr_hit = sample_en;
        if (idx == LAST_IDX) next_state = SAT;
      end
      SAT: begin
        ovr_hit = sample_en;
`ifdef AUDIO_MIXER_DCBLOCK_EN
        next_state = DCB;
`else
        next_state = IDLE;
`endif
      end
`ifdef AUDIO_MIXER_DCBLOCK_EN
      DCB: begin
        ovr_hit    = sample_en;
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Select the channel being accumulated and convert offset-binary to signed.
  always_comb begin
    raw = '0;
    g_l = '0;
    g_r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == IDXW'(k)) begin
        raw = snap[k*IW +: IW];
        g_l = cur_l[k];
        g_r = cur_r[k];
      end
    end
    s      = {~raw[IW-1], raw[IW-2:0]};
    prod_l = PW'(s) * PW'($signed({1'b0, g_l}));
    prod_r = PW'(s) * PW'($signed({1'b0, g_r}));
  end

  // Rescale the accumulators to the output format and clamp.
  always_comb begin
    wide_l = (64'(acc_l) >>> (GW - 1)) <<< (OW - IW);
    wide_r = (64'(acc_r) >>> (GW - 1)) <<< (OW - IW);
    sat_l  = OW'(sat_to_ow(wide_l, OW));
    sat_r  = OW'(sat_to_ow(wide_r, OW));
  end

  // Combinational readback of the target gain register at reg_addr.
  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (reg_addr == AW'(k))       reg_rdata = tgt_l[k];
      if (reg_addr == AW'(k + NCH)) reg_rdata = tgt_r[k];
    end
  end

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic [OW-1:0] dcb_y_l;
  logic [OW-1:0] dcb_y_r;
  logic          dcb_en;

  assign dcb_en = (state == SAT);

  audio_dc_block #(.OW(OW), .DC_SHIFT(DC_SHIFT)) u_dcb_l (
    .clk   (clk),
    .reset (reset),
    .en    (dcb_en),
    .x     (sat_l),
    .y     (dcb_y_l)
  );

  audio_dc_block #(.OW(OW), .DC_SHIFT(DC_SHIFT)) u_dcb_r (
    .clk   (clk),
    .reset (reset),
    .en    (dcb_en),
    .x     (sat_r),
    .y     (dcb_y_r)
  );
`endif

  // Gain registers, ramping, snapshot, MAC accumulation and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap      <= '0;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        tgt_l[k] <= UNITY;
        tgt_r[k] <= UNITY;
        cur_l[k] <= UNITY;
        cur_r[k] <= UNITY;
      end
    end else begin
      overrun   <= ovr_hit;
      out_valid <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (reg_wr && reg_addr == AW'(k))       tgt_l[k] <= reg_wdata;
        if (reg_wr && reg_addr == AW'(k + NCH)) tgt_r[k] <= reg_wdata;
      end
      case (state)
        IDLE: begin
          if (start_frame) begin
            snap  <= in_samples;
            acc_l <= '0;
            acc_r <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            for (int k = 0; k < NCH; k++) begin
              cur_l[k] <= ramp_step(cur_l[k], tgt_l[k]);
              cur_r[k] <= ramp_step(cur_r[k], tgt_r[k]);
            end
          end
        end
        ACC: begin
          acc_l <= acc_l + ACC_W'(prod_l);
          acc_r <= acc_r + ACC_W'(prod_r);
          if (idx == LAST_IDX) idx <= '0;
          else                 idx <= idx + IDXW'(1);
        end
`ifdef AUDIO_MIXER_DCBLOCK_EN
        SAT: begin
        end
        DCB: begin
          out_l     <= dcb_y_l;
          out_r     <= dcb_y_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
`else
        SAT: begin
          out_l     <= sat_l;
          out_r     <= sat_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
